// File: rtl/mcp_adc_responder_if.sv
// mcp_adc_responder_if: SPI pins plus sample/status handshake of the MCP ADC responder
interface mcp_adc_responder_if #(
   parameter int DATA_W = 10
);
   logic              cs;
   logic              sclk;
   logic              din;
   logic              dout;
   logic              dout_oe;
   logic [2:0]        chan;
   logic              sgl_diff;
   logic              chan_req;
   logic [DATA_W-1:0] sample_data;
   logic              busy;
   logic              frame_done;
   logic              frame_abort;
   modport slave (
      input  cs, sclk, din, sample_data,
      output dout, dout_oe, chan, sgl_diff, chan_req, busy, frame_done, frame_abort
   );
   modport master (
      output cs, sclk, din, sample_data,
      input  dout, dout_oe, chan, sgl_diff, chan_req, busy, frame_done, frame_abort
   );
endinterface

// File: rtl/mcp_adc_responder.sv
// mcp_adc_responder: SPI slave emulating an MCP-style ADC, oversampling the SPI pins on clk
module mcp_adc_responder #(
   parameter int DATA_W      = 10,
   parameter int SYNC_STAGES = 2
) (
   input logic                clk,
   input logic                rst,
   mcp_adc_responder_if.slave bus
);
   localparam int CW = $clog2(DATA_W + 4);
   typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_CMD, S_SAMPLE, S_NULL, S_DATA, S_TAIL} state_t;
   state_t                 state_q;
   logic [SYNC_STAGES-1:0] cs_sq, sclk_sq, din_sq;
   logic                   cs_pq, sclk_pq;
   logic [2:0]             cmd_q;
   logic [CW-1:0]          bitcnt_q;
   logic [DATA_W-1:0]      shreg_q;
   logic                   dout_q, dout_oe_q, sgl_diff_q, chan_req_q, busy_q, frame_done_q, frame_abort_q;
   logic [2:0]             chan_q;
   logic                   cs_s, din_s, cs_fall, sclk_rise, sclk_fall;
   logic [3:0]             cmd_d;
   assign cs_s      = cs_sq[SYNC_STAGES-1];
   assign din_s     = din_sq[SYNC_STAGES-1];
   assign cs_fall   = !cs_s && cs_pq;
   assign sclk_rise = sclk_sq[SYNC_STAGES-1] && !sclk_pq;
   assign sclk_fall = !sclk_sq[SYNC_STAGES-1] && sclk_pq;
   assign cmd_d     = {cmd_q, din_s};
   assign bus.dout        = dout_q;
   assign bus.dout_oe     = dout_oe_q;
   assign bus.chan        = chan_q;
   assign bus.sgl_diff    = sgl_diff_q;
   assign bus.chan_req    = chan_req_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.frame_abort = frame_abort_q;
   // Synchronize the SPI pins and keep one extra copy of cs/sclk for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sq   <= '0;
         sclk_sq <= '0;
         din_sq  <= '0;
         cs_pq   <= 1'b0;
         sclk_pq <= 1'b0;
      end else begin
         cs_sq   <= {cs_sq[SYNC_STAGES-2:0], bus.cs};
         sclk_sq <= {sclk_sq[SYNC_STAGES-2:0], bus.sclk};
         din_sq  <= {din_sq[SYNC_STAGES-2:0], bus.din};
         cs_pq   <= cs_s;
         sclk_pq <= sclk_sq[SYNC_STAGES-1];
      end
   end
   // Frame FSM: command capture on sclk rises, result shifted out on sclk falls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cmd_q         <= '0;
         bitcnt_q      <= '0;
         shreg_q       <= '0;
         dout_q        <= 1'b0;
         dout_oe_q     <= 1'b0;
         chan_q        <= '0;
         sgl_diff_q    <= 1'b0;
         chan_req_q    <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         chan_req_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
         if (cs_s) begin
            frame_done_q  <= state_q == S_TAIL;
            frame_abort_q <= state_q inside {S_CMD, S_SAMPLE, S_NULL, S_DATA};
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            dout_oe_q     <= 1'b0;
            dout_q        <= 1'b0;
            bitcnt_q      <= '0;
         end else begin
            case (state_q)
               S_IDLE: if (cs_fall) begin
                  state_q <= S_WAIT_START;
                  busy_q  <= 1'b1;
               end
               S_WAIT_START: if (sclk_rise && din_s) begin
                  state_q  <= S_CMD;
                  bitcnt_q <= '0;
               end
               S_CMD: if (sclk_rise) begin
                  cmd_q    <= cmd_d[2:0];
                  bitcnt_q <= bitcnt_q + 1'b1;
                  if (bitcnt_q == CW'(3)) begin
                     chan_q     <= cmd_d[2:0];
                     sgl_diff_q <= cmd_d[3];
                     chan_req_q <= 1'b1;
                     bitcnt_q   <= '0;
                     state_q    <= S_SAMPLE;
                  end
               end
               // dout_oe doubles as the "first fall already seen" marker of the sample period
               S_SAMPLE: if (sclk_fall) begin
                  dout_q <= 1'b0;
                  if (dout_oe_q) state_q <= S_NULL;
                  else begin
                     shreg_q   <= bus.sample_data;
                     dout_oe_q <= 1'b1;
                  end
               end
               S_NULL: if (sclk_fall) begin
                  dout_q   <= shreg_q[DATA_W-1];
                  shreg_q  <= shreg_q << 1;
                  bitcnt_q <= CW'(1);
                  state_q  <= S_DATA;
               end
               S_DATA: if (sclk_fall) begin
                  dout_q   <= shreg_q[DATA_W-1];
                  shreg_q  <= shreg_q << 1;
                  bitcnt_q <= bitcnt_q + 1'b1;
                  if (bitcnt_q == CW'(DATA_W-1)) state_q <= S_TAIL;
               end
               S_TAIL: if (sclk_fall) dout_q <= 1'b0;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mcp_adc_responder.sv
// tb_mcp_adc_responder: directed SPI frames against a 10-bit and a 12-bit responder sharing the pins
module tb_mcp_adc_responder;
   localparam int LAT = 3;
   logic        clk = 1'b0, rst = 1'b1, cs = 1'b1, sclk = 1'b0, din = 1'b0;
   logic [9:0]  sd10 = '0;
   logic [11:0] sd12 = '0;
   logic [11:0] w10, w12;
   int tests = 0, fails = 0;
   int lo_cnt = 0, hi_cnt = 0;
   bit seen_high = 1'b0;
   int nreq10 = 0, ndone10 = 0, nab10 = 0, nreq12 = 0, ndone12 = 0, nab12 = 0;
   mcp_adc_responder_if #(.DATA_W(10)) b10();
   mcp_adc_responder_if #(.DATA_W(12)) b12();
   assign b10.cs = cs;
   assign b10.sclk = sclk;
   assign b10.din = din;
   assign b10.sample_data = sd10;
   assign b12.cs = cs;
   assign b12.sclk = sclk;
   assign b12.din = din;
   assign b12.sample_data = sd12;
   mcp_adc_responder #(.DATA_W(10), .SYNC_STAGES(2)) d10 (.clk(clk), .rst(rst), .bus(b10.slave));
   mcp_adc_responder #(.DATA_W(12), .SYNC_STAGES(2)) d12 (.clk(clk), .rst(rst), .bus(b12.slave));
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: bits the master reads on the rises after D0 -- sample period, null, data MSB-first, zeros
   function automatic logic exp_bit(input int w, input logic [11:0] v, input int k);
      return (k >= 2 && k < 2 + w) ? v[w-1-(k-2)] : 1'b0;
   endfunction

   // Reference busy: low cs seen LAT clocks ago, starting only after cs was high since reset
   always @(posedge clk) begin
      if (rst) begin
         lo_cnt <= 0;
         hi_cnt <= 0;
         seen_high <= 1'b0;
      end else begin
         lo_cnt <= cs ? 0 : lo_cnt + 1;
         hi_cnt <= cs ? hi_cnt + 1 : 0;
         seen_high <= seen_high | (cs && hi_cnt >= LAT - 1);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy10", b10.busy, seen_high && (lo_cnt >= LAT || (hi_cnt > 0 && hi_cnt < LAT)));
         chk("busy12", b12.busy, seen_high && (lo_cnt >= LAT || (hi_cnt > 0 && hi_cnt < LAT)));
         if (!b10.dout_oe) chk("dout_hiz10", b10.dout, 0);
         if (!b12.dout_oe) chk("dout_hiz12", b12.dout, 0);
         if (b10.chan_req) nreq10 <= nreq10 + 1;
         if (b10.frame_done) ndone10 <= ndone10 + 1;
         if (b10.frame_abort) nab10 <= nab10 + 1;
         if (b12.chan_req) nreq12 <= nreq12 + 1;
         if (b12.frame_done) ndone12 <= ndone12 + 1;
         if (b12.frame_abort) nab12 <= nab12 + 1;
      end
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic sclk_bit(input logic d);
      din = d;
      wclk(6);
      sclk = 1'b1;
      wclk(6);
      sclk = 1'b0;
   endtask

   task automatic frame(input int nlead, input logic [3:0] cmd, input int nrd, input int gap,
                        output logic [11:0] o10, output logic [11:0] o12);
      int r10, r12, d10, d12, a10, a12;
      r10 = nreq10; r12 = nreq12; d10 = ndone10; d12 = ndone12; a10 = nab10; a12 = nab12;
      o10 = '0;
      o12 = '0;
      cs = 1'b0;
      wclk(8);
      repeat (nlead) sclk_bit(1'b0);
      sclk_bit(1'b1);
      for (int i = 3; i >= 0; i--) sclk_bit(cmd[i]);
      for (int k = 0; k < nrd; k++) begin
         din = 1'b0;
         wclk(6);
         sclk = 1'b1;
         chk("bit10", b10.dout, exp_bit(10, {2'b00, sd10}, k));
         chk("bit12", b12.dout, exp_bit(12, sd12, k));
         chk("oe_on10", b10.dout_oe, 1);
         chk("oe_on12", b12.dout_oe, 1);
         if (k >= 2 && k < 12) o10 = {o10[10:0], b10.dout};
         if (k >= 2 && k < 14) o12 = {o12[10:0], b12.dout};
         wclk(6);
         sclk = 1'b0;
      end
      wclk(6);
      chk("chan_req10", nreq10 - r10, 1);
      chk("chan_req12", nreq12 - r12, 1);
      chk("chan10", b10.chan, cmd[2:0]);
      chk("sgl10", b10.sgl_diff, cmd[3]);
      chk("chan12", b12.chan, cmd[2:0]);
      chk("sgl12", b12.sgl_diff, cmd[3]);
      cs = 1'b1;
      wclk(gap);
      if (gap < 6) begin
         cs = 1'b0;
         wclk(6);
      end
      chk("done10", ndone10 - d10, nrd >= 12);
      chk("abort10", nab10 - a10, nrd < 12);
      chk("done12", ndone12 - d12, nrd >= 14);
      chk("abort12", nab12 - a12, nrd < 14);
      chk("oe_off10", b10.dout_oe, 0);
      chk("oe_off12", b12.dout_oe, 0);
   endtask

   initial begin
      int r10, d10, a10, r12;
      wclk(3);
      chk("rst_oe", b10.dout_oe, 0);
      chk("rst_dout", b10.dout, 0);
      chk("rst_busy", b10.busy, 0);
      chk("rst_chan", b10.chan, 0);
      chk("rst_sgl", b10.sgl_diff, 0);
      chk("rst_req", b10.chan_req, 0);
      chk("rst_done", b10.frame_done, 0);
      chk("rst_abort", b10.frame_abort, 0);
      chk("rst_oe12", b12.dout_oe, 0);
      rst = 1'b0;
      wclk(8);
      sd10 = 10'h2A5; sd12 = 12'h123;
      frame(0, 4'b1101, 12, 6, w10, w12);
      chk("full_word", w10, 12'h2A5);
      chk("full_chan", b10.chan, 3'd5);
      chk("full_sgl", b10.sgl_diff, 1'b1);
      sd10 = 10'h3FF; sd12 = 12'hFFF;
      frame(3, 4'b0011, 14, 6, w10, w12);
      chk("lead_word", w10, 12'h3FF);
      chk("lead_chan", b10.chan, 3'd3);
      chk("lead_sgl", b10.sgl_diff, 1'b0);
      sd10 = 10'h155; sd12 = 12'h555;
      frame(0, 4'b1010, 6, 6, w10, w12);
      sd10 = 10'h001; sd12 = 12'h001;
      frame(1, 4'b1111, 12, 6, w10, w12);
      chk("after_abort_word", w10, 12'h001);
      sd10 = 10'h0C3; sd12 = 12'h3C3;
      frame(0, 4'b1001, 16, 2, w10, w12);
      sd10 = 10'h15A; sd12 = 12'h95A;
      frame(0, 4'b1100, 12, 6, w10, w12);
      chk("b2b_word", w10, 12'h15A);
      sd10 = 10'h2C4; sd12 = 12'hA5C;
      frame(0, 4'b0110, 14, 6, w10, w12);
      chk("w12_word", w12, 12'hA5C);
      sd10 = 10'h3F0; sd12 = 12'hF0F;
      cs = 1'b0;
      wclk(8);
      sclk_bit(1'b1); sclk_bit(1'b1); sclk_bit(1'b0); sclk_bit(1'b1); sclk_bit(1'b0);
      repeat (6) sclk_bit(1'b0);
      wclk(3);
      r10 = nreq10; d10 = ndone10; a10 = nab10; r12 = nreq12;
      rst = 1'b1;
      #1;
      chk("mid_rst_oe10", b10.dout_oe, 0);
      chk("mid_rst_dout10", b10.dout, 0);
      chk("mid_rst_busy10", b10.busy, 0);
      chk("mid_rst_oe12", b12.dout_oe, 0);
      chk("mid_rst_busy12", b12.busy, 0);
      wclk(3);
      rst = 1'b0;
      wclk(6);
      chk("post_rst_req", nreq10 - r10, 0);
      chk("post_rst_req12", nreq12 - r12, 0);
      chk("post_rst_done", ndone10 - d10, 0);
      chk("post_rst_abort", nab10 - a10, 0);
      chk("post_rst_busy", b10.busy, 0);
      cs = 1'b1;
      wclk(6);
      cs = 1'b0;
      wclk(4);
      chk("restart_busy10", b10.busy, 1);
      chk("restart_busy12", b12.busy, 1);
      frame(0, 4'b1110, 14, 6, w10, w12);
      chk("post_rst_word", w10, 12'h3F0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
